// File: rtl/reg_file.sv
// reg_file: 8x16 architectural register file with R0 tied to zero and a registered NZCV flags word.
module reg_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_negative,
  output logic [3:0]        flags
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [3:0]        flags_q, flags_d;
  // Reads see only registered state, so a write never bypasses to the ALU operands.
  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
  assign flags     = flags_q;
  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != '0) regs_d[wr_addr] = wr_data;
    flags_d = flag_we ? {alu_negative, alu_zero, alu_carry, alu_overflow} : flags_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q  <= '{default: '0};
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file against an array-based reference model.
module tb_reg_file;
  logic        clk = 0;
  logic        rst;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en, flag_we, alu_carry, alu_overflow, alu_zero, alu_negative;
  logic [3:0]  flags;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] mreg [8];
  logic [3:0]  mflags;
  bit          mvalid = 0;

  reg_file dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an array of register values plus a flags word, updated at each edge.
  always @(posedge clk) begin
    if (rst) begin
      foreach (mreg[i]) mreg[i] = 16'h0;
      mflags = 4'h0;
      mvalid = 1;
    end else begin
      if (wr_en === 1'b1 && wr_addr != 3'd0) mreg[wr_addr] = wr_data;
      if (flag_we === 1'b1) mflags = {alu_negative, alu_zero, alu_carry, alu_overflow};
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_rd_a", rd_data_a, mreg[rd_addr_a]);
      chk("model_rd_b", rd_data_b, mreg[rd_addr_b]);
      chk("model_flags", {12'h0, flags}, {12'h0, mflags});
    end
  end

  initial begin
    rst = 1; wr_en = 0; flag_we = 0; wr_addr = 0; wr_data = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'hF;
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      @(negedge clk);
      chk("reset_rd_a", rd_data_a, 16'h0);
      chk("reset_rd_b", rd_data_b, 16'h0);
    end
    chk("reset_flags", {12'h0, flags}, 16'h0);
    tick();
    wr_en = 1; wr_addr = 3; wr_data = 16'hA5A5;
    tick();
    wr_addr = 5; wr_data = 16'h5A5A;
    tick();
    wr_en = 0; rd_addr_a = 3; rd_addr_b = 5;
    @(negedge clk);
    chk("wr_r3", rd_data_a, 16'hA5A5);
    chk("wr_r5", rd_data_b, 16'h5A5A);
    tick();
    wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF;
    tick();
    wr_en = 0; rd_addr_a = 0;
    @(negedge clk);
    chk("r0_zero", rd_data_a, 16'h0);
    tick();
    wr_en = 1; wr_addr = 2; wr_data = 16'h0001;
    tick();
    wr_data = 16'h0002; rd_addr_a = 2;
    @(negedge clk);
    chk("nobypass_old", rd_data_a, 16'h0001);
    tick();
    wr_en = 0;
    @(negedge clk);
    chk("nobypass_new", rd_data_a, 16'h0002);
    tick();
    flag_we = 1; {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b1010;
    tick();
    flag_we = 0; {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b1111;
    @(negedge clk);
    chk("flags_cap", {12'h0, flags}, 16'h000A);
    tick();
    @(negedge clk);
    chk("flags_hold", {12'h0, flags}, 16'h000A);
    tick();
    rst = 1; wr_en = 1; wr_addr = 4; wr_data = 16'h1234; flag_we = 1;
    tick();
    rst = 0; wr_en = 0; flag_we = 0; rd_addr_a = 4;
    @(negedge clk);
    chk("rstprio_r4", rd_data_a, 16'h0);
    chk("rstprio_flags", {12'h0, flags}, 16'h0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      wr_en     = 1'($urandom);
      wr_addr   = wr_en ? 3'($urandom) : 3'bxxx;
      wr_data   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      flag_we   = 1'($urandom);
      {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'($urandom);
      rd_addr_a = 3'($urandom);
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr_a = wr_addr;
      tick();
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
